// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: instruction/memory handshakes and datapath control lines.
// The trap line exists only when ILLEGAL_TRAP_EN is defined.
interface multicycle_control_unit_if;
  logic [31:0] instr;
  logic        zero;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        ir_we;
  logic        dmem_req;
  logic        dmem_we;
  logic [2:0]  imm_sel;
  logic        alu_src;
  logic        alu_op;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        pc_we;
  logic        pc_sel;
  logic [31:0] instret;
  logic [2:0]  state_o;
`ifdef ILLEGAL_TRAP_EN
  logic        trap;
`endif

  // Control unit side
  modport master (
    input  instr, zero, imem_ready, dmem_ready,
    output imem_req, ir_we, dmem_req, dmem_we, imm_sel, alu_src, alu_op,
           reg_we, wb_sel, pc_we, pc_sel, instret, state_o
`ifdef ILLEGAL_TRAP_EN
    , output trap
`endif
  );

  // Datapath / memory side
  modport slave (
    output instr, zero, imem_ready, dmem_ready,
    input  imem_req, ir_we, dmem_req, dmem_we, imm_sel, alu_src, alu_op,
           reg_we, wb_sel, pc_we, pc_sel, instret, state_o
`ifdef ILLEGAL_TRAP_EN
    , input trap
`endif
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for addi/lw/sw/beq/jal.
// Optional: define ILLEGAL_TRAP_EN to send illegal opcodes to a sticky TRAP
// state; otherwise illegal opcodes retire as NOPs.
module multicycle_control_unit #(
  parameter logic [31:0] INSTRET_RST = '0  // instret reset value, bring-up hook
) (
  input logic                       clk,
  input logic                       rst_n,
  multicycle_control_unit_if.master bus
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t      r_state;
  state_t      w_next;
  logic [6:0]  r_op_q;
  logic [31:0] r_instret;

  logic        w_imem_req, w_ir_we, w_dmem_req, w_dmem_we;
  logic [2:0]  w_imm_sel, w_imm;
  logic        w_alu_src, w_alu_op, w_reg_we, w_pc_we, w_pc_sel;
  logic [1:0]  w_wb_sel;
  logic        w_rd_nz, w_legal;
  logic        w_unused_instr;
`ifdef ILLEGAL_TRAP_EN
  logic        w_trap;
`endif

  assign w_rd_nz        = |bus.instr[11:7];
  assign w_legal        = bus.instr[6:0] inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JAL};
  assign w_unused_instr = &{1'b0, bus.instr[31:12]};

  // State, latched opcode and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_op_q    <= '0;
      r_instret <= INSTRET_RST;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op_q <= bus.instr[6:0];
      if (w_pc_we) r_instret <= r_instret + 32'd1;
    end
  end

  // Immediate format implied by the latched opcode
  always_comb begin
    w_imm = '0;
    case (r_op_q)
      OP_ADDI, OP_LW: w_imm = 3'd1;
      OP_SW:          w_imm = 3'd2;
      OP_BEQ:         w_imm = 3'd3;
      OP_JAL:         w_imm = 3'd4;
      default:        w_imm = '0;
    endcase
  end

  // Next-state and control-line decode
  always_comb begin
    w_next     = r_state;
    w_imem_req = 1'b0;
    w_ir_we    = 1'b0;
    w_dmem_req = 1'b0;
    w_dmem_we  = 1'b0;
    w_imm_sel  = '0;
    w_alu_src  = 1'b0;
    w_alu_op   = 1'b0;
    w_reg_we   = 1'b0;
    w_wb_sel   = '0;
    w_pc_we    = 1'b0;
    w_pc_sel   = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    w_trap     = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (bus.imem_ready) begin
          w_ir_we = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_legal) begin
          w_next = S_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          w_next = S_TRAP;
`else
          w_pc_we = 1'b1;
          w_next  = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        w_imm_sel = w_imm;
        case (r_op_q)
          OP_ADDI: begin
            w_alu_src = 1'b1;
            w_next    = S_WB;
          end
          OP_LW, OP_SW: begin
            w_alu_src = 1'b1;
            w_next    = S_MEM;
          end
          OP_BEQ: begin
            w_alu_op = 1'b1;
            w_pc_we  = 1'b1;
            w_pc_sel = bus.zero;
            w_next   = S_FETCH;
          end
          OP_JAL: begin
            w_reg_we = w_rd_nz;
            w_wb_sel = 2'd2;
            w_pc_we  = 1'b1;
            w_pc_sel = 1'b1;
            w_next   = S_FETCH;
          end
          default: w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        w_imm_sel  = w_imm;
        w_dmem_req = 1'b1;
        w_dmem_we  = (r_op_q == OP_SW);
        if (bus.dmem_ready) begin
          if (r_op_q == OP_SW) begin
            w_pc_we = 1'b1;
            w_next  = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        w_imm_sel = w_imm;
        w_reg_we  = w_rd_nz;
        w_wb_sel  = (r_op_q == OP_LW) ? 2'd1 : 2'd0;
        w_pc_we   = 1'b1;
        w_next    = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: w_trap = 1'b1;
`endif
      default: w_next = S_FETCH;
    endcase
  end

  // ir_we is masked by reset so a ready memory cannot load IR while held in reset
  assign bus.imem_req = w_imem_req;
  assign bus.ir_we    = w_ir_we & rst_n;
  assign bus.dmem_req = w_dmem_req;
  assign bus.dmem_we  = w_dmem_we;
  assign bus.imm_sel  = w_imm_sel;
  assign bus.alu_src  = w_alu_src;
  assign bus.alu_op   = w_alu_op;
  assign bus.reg_we   = w_reg_we;
  assign bus.wb_sel   = w_wb_sel;
  assign bus.pc_we    = w_pc_we;
  assign bus.pc_sel   = w_pc_sel;
  assign bus.instret  = r_instret;
  assign bus.state_o  = r_state;
`ifdef ILLEGAL_TRAP_EN
  assign bus.trap     = w_trap;
`endif
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit; trap checks follow ILLEGAL_TRAP_EN.
module tb_multicycle_control_unit;
  localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] I_LW   = 32'h0040A103;  // lw   x2,4(x1)
  localparam logic [31:0] I_SW   = 32'h0020A023;  // sw   x2,0(x1)
  localparam logic [31:0] I_BEQ  = 32'h00208463;  // beq  x1,x2,8
  localparam logic [31:0] I_JAL0 = 32'h0080006F;  // jal  x0,8
  localparam logic [31:0] I_JAL1 = 32'h008000EF;  // jal  x1,8
  localparam logic [31:0] I_LUI  = 32'h000011B7;  // lui  x3,1 (not supported)

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  multicycle_control_unit_if bus ();
  multicycle_control_unit_if bus2 ();

  multicycle_control_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  multicycle_control_unit #(.INSTRET_RST(32'hFFFF_FFFF)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Field order: state, imem_req, ir_we, dmem_req, dmem_we, imm_sel, alu_src,
  // alu_op, reg_we, wb_sel, pc_we, pc_sel
  function automatic logic [16:0] ev(input int st, input int ireq, input int irwe,
                                     input int dreq, input int dwe, input int imm,
                                     input int asrc, input int aop, input int rwe,
                                     input int wb, input int pcwe, input int pcsel);
    ev = {st[2:0], ireq[0], irwe[0], dreq[0], dwe[0], imm[2:0], asrc[0], aop[0],
          rwe[0], wb[1:0], pcwe[0], pcsel[0]};
  endfunction

  function automatic logic [16:0] obs();
    obs = {bus.state_o, bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we, bus.imm_sel,
           bus.alu_src, bus.alu_op, bus.reg_we, bus.wb_sel, bus.pc_we, bus.pc_sel};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.instr = I_ADDI; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1; bus.zero = 1'b1;
    repeat (2) next_cycle();
    tests++;
    if (obs() !== ev(0,1,0,0,0,0,0,0,0,0,0,0)) begin
      $display("FAIL reset_outputs: got %05h expected %05h", obs(), ev(0,1,0,0,0,0,0,0,0,0,0,0));
      fails++;
    end
    tests++;
    if (bus.instret !== 32'd0) begin
      $display("FAIL reset_instret: got %h expected 0", bus.instret);
      fails++;
    end
`ifdef ILLEGAL_TRAP_EN
    tests++;
    if (bus.trap !== 1'b0) begin
      $display("FAIL reset_trap: got %b expected 0", bus.trap);
      fails++;
    end
`endif
    bus.imem_ready = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++;
      if (obs() !== ev(0,1,0,0,0,0,0,0,0,0,0,0)) begin
        $display("FAIL fetch_stall[%0d]: got %05h expected %05h", i, obs(), ev(0,1,0,0,0,0,0,0,0,0,0,0));
        fails++;
      end
      next_cycle();
    end
  endtask

  task automatic test_addi();
    logic [16:0] ex [4];
    ex[0] = ev(0,1,1,0,0,0,0,0,0,0,0,0);
    ex[1] = ev(1,0,0,0,0,0,0,0,0,0,0,0);
    ex[2] = ev(2,0,0,0,0,1,1,0,0,0,0,0);
    ex[3] = ev(4,0,0,0,0,1,0,0,1,0,1,0);
    bus.instr = I_ADDI; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1; bus.zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (obs() !== ex[i]) begin
        $display("FAIL addi[%0d]: got %05h expected %05h", i, obs(), ex[i]);
        fails++;
      end
      next_cycle();
    end
    #1;
    tests++;
    if (bus.state_o !== 3'd0 || bus.instret !== 32'd1) begin
      $display("FAIL addi_retire: got state %0d instret %0d expected state 0 instret 1", bus.state_o, bus.instret);
      fails++;
    end
  endtask

  task automatic test_lw();
    logic [16:0] ex [8];
    logic [7:0]  drdy;
    drdy  = 8'b0100_0111;  // ready ignored in F/D/E, low 3 cycles in MEM, then high
    ex[0] = ev(0,1,1,0,0,0,0,0,0,0,0,0);
    ex[1] = ev(1,0,0,0,0,0,0,0,0,0,0,0);
    ex[2] = ev(2,0,0,0,0,1,1,0,0,0,0,0);
    for (int i = 3; i < 7; i++) ex[i] = ev(3,0,0,1,0,1,0,0,0,0,0,0);
    ex[7] = ev(4,0,0,0,0,1,0,0,1,1,1,0);
    bus.instr = I_LW; bus.imem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.dmem_ready = drdy[i];
      #1;
      tests++;
      if (obs() !== ex[i]) begin
        $display("FAIL lw[%0d]: got %05h expected %05h", i, obs(), ex[i]);
        fails++;
      end
      next_cycle();
    end
    #1;
    tests++;
    if (bus.state_o !== 3'd0 || bus.instret !== 32'd2) begin
      $display("FAIL lw_retire: got state %0d instret %0d expected state 0 instret 2", bus.state_o, bus.instret);
      fails++;
    end
  endtask

  task automatic test_sw();
    logic [16:0] ex [4];
    ex[0] = ev(0,1,1,0,0,0,0,0,0,0,0,0);
    ex[1] = ev(1,0,0,0,0,0,0,0,0,0,0,0);
    ex[2] = ev(2,0,0,0,0,2,1,0,0,0,0,0);
    ex[3] = ev(3,0,0,1,1,2,0,0,0,0,1,0);
    bus.instr = I_SW; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (obs() !== ex[i]) begin
        $display("FAIL sw[%0d]: got %05h expected %05h", i, obs(), ex[i]);
        fails++;
      end
      next_cycle();
    end
    #1;
    tests++;
    if (bus.state_o !== 3'd0 || bus.instret !== 32'd3) begin
      $display("FAIL sw_retire: got state %0d instret %0d expected state 0 instret 3", bus.state_o, bus.instret);
      fails++;
    end
  endtask

  task automatic test_back_to_back_beq();
    logic [16:0] ex [3];
    bus.instr = I_BEQ; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      bus.zero = (r == 0);
      ex[0] = ev(0,1,1,0,0,0,0,0,0,0,0,0);
      ex[1] = ev(1,0,0,0,0,0,0,0,0,0,0,0);
      ex[2] = ev(2,0,0,0,0,3,0,1,0,0,1,(r == 0) ? 1 : 0);
      for (int i = 0; i < 3; i++) begin
        #1;
        tests++;
        if (obs() !== ex[i]) begin
          $display("FAIL beq_z%0d[%0d]: got %05h expected %05h", 1 - r, i, obs(), ex[i]);
          fails++;
        end
        next_cycle();
      end
    end
    #1;
    tests++;
    if (bus.state_o !== 3'd0 || bus.instret !== 32'd5) begin
      $display("FAIL beq_retire: got state %0d instret %0d expected state 0 instret 5", bus.state_o, bus.instret);
      fails++;
    end
  endtask

  task automatic test_jal();
    logic [16:0] ex [3];
    bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0; bus.zero = 1'b0;
    for (int r = 0; r < 2; r++) begin
      bus.instr = (r == 0) ? I_JAL0 : I_JAL1;
      ex[0] = ev(0,1,1,0,0,0,0,0,0,0,0,0);
      ex[1] = ev(1,0,0,0,0,0,0,0,0,0,0,0);
      ex[2] = ev(2,0,0,0,0,4,0,0,r,2,1,1);
      for (int i = 0; i < 3; i++) begin
        #1;
        tests++;
        if (obs() !== ex[i]) begin
          $display("FAIL jal_rd%0d[%0d]: got %05h expected %05h", r, i, obs(), ex[i]);
          fails++;
        end
        next_cycle();
      end
    end
    #1;
    tests++;
    if (bus.state_o !== 3'd0 || bus.instret !== 32'd7) begin
      $display("FAIL jal_retire: got state %0d instret %0d expected state 0 instret 7", bus.state_o, bus.instret);
      fails++;
    end
  endtask

  task automatic test_illegal();
    bus.instr = I_LUI; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
    #1;
    tests++;
    if (obs() !== ev(0,1,1,0,0,0,0,0,0,0,0,0)) begin
      $display("FAIL illegal_fetch: got %05h expected %05h", obs(), ev(0,1,1,0,0,0,0,0,0,0,0,0));
      fails++;
    end
    next_cycle();
`ifdef ILLEGAL_TRAP_EN
    #1;
    tests++;
    if (obs() !== ev(1,0,0,0,0,0,0,0,0,0,0,0)) begin
      $display("FAIL illegal_decode: got %05h expected %05h", obs(), ev(1,0,0,0,0,0,0,0,0,0,0,0));
      fails++;
    end
    next_cycle();
    bus.instr = I_ADDI;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (obs() !== ev(5,0,0,0,0,0,0,0,0,0,0,0) || bus.trap !== 1'b1) begin
        $display("FAIL trap_hold[%0d]: got %05h trap %b expected %05h trap 1", i, obs(), bus.trap, ev(5,0,0,0,0,0,0,0,0,0,0,0));
        fails++;
      end
      next_cycle();
    end
    #1;
    tests++;
    if (bus.instret !== 32'd7) begin
      $display("FAIL trap_instret: got %0d expected 7", bus.instret);
      fails++;
    end
`else
    #1;
    tests++;
    if (obs() !== ev(1,0,0,0,0,0,0,0,0,0,1,0)) begin
      $display("FAIL illegal_nop: got %05h expected %05h", obs(), ev(1,0,0,0,0,0,0,0,0,0,1,0));
      fails++;
    end
    next_cycle();
    #1;
    tests++;
    if (bus.state_o !== 3'd0 || bus.instret !== 32'd8) begin
      $display("FAIL illegal_retire: got state %0d instret %0d expected state 0 instret 8", bus.state_o, bus.instret);
      fails++;
    end
`endif
  endtask

  task automatic test_reset_mid_mem();
    rst_n = 1'b0;
    next_cycle();
    bus.instr = I_LW; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
    rst_n = 1'b1;
    repeat (3) next_cycle();
    #1;
    tests++;
    if (obs() !== ev(3,0,0,1,0,1,0,0,0,0,0,0)) begin
      $display("FAIL mid_mem_before: got %05h expected %05h", obs(), ev(3,0,0,1,0,1,0,0,0,0,0,0));
      fails++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs() !== ev(0,1,0,0,0,0,0,0,0,0,0,0) || bus.instret !== 32'd0) begin
      $display("FAIL mid_mem_reset: got %05h instret %0d expected %05h instret 0", obs(), bus.instret, ev(0,1,0,0,0,0,0,0,0,0,0,0));
      fails++;
    end
    next_cycle();
    bus.instr = I_ADDI;
    rst_n = 1'b1;
    next_cycle();
    tests++;
    if (bus.state_o !== 3'd1) begin
      $display("FAIL first_fetch: got state %0d expected 1", bus.state_o);
      fails++;
    end
    repeat (3) next_cycle();
    tests++;
    if (bus.state_o !== 3'd0 || bus.instret !== 32'd1) begin
      $display("FAIL post_reset_addi: got state %0d instret %0d expected state 0 instret 1", bus.state_o, bus.instret);
      fails++;
    end
  endtask

  task automatic test_instret_wrap();
    bus2.instr = I_SW; bus2.imem_ready = 1'b1; bus2.dmem_ready = 1'b1;
    #1;
    tests++;
    if (bus2.instret !== 32'hFFFF_FFFF) begin
      $display("FAIL wrap_preload: got %h expected ffffffff", bus2.instret);
      fails++;
    end
    repeat (3) next_cycle();
    tests++;
    if (bus2.state_o !== 3'd3 || bus2.pc_we !== 1'b1) begin
      $display("FAIL wrap_mem: got state %0d pc_we %b expected state 3 pc_we 1", bus2.state_o, bus2.pc_we);
      fails++;
    end
    next_cycle();
    tests++;
    if (bus2.state_o !== 3'd0 || bus2.instret !== 32'd0) begin
      $display("FAIL wrap_result: got state %0d instret %h expected state 0 instret 00000000", bus2.state_o, bus2.instret);
      fails++;
    end
    bus2.imem_ready = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.instr  = '0; bus.zero  = 1'b0; bus.imem_ready  = 1'b0; bus.dmem_ready  = 1'b0;
    bus2.instr = '0; bus2.zero = 1'b0; bus2.imem_ready = 1'b0; bus2.dmem_ready = 1'b0;
    test_reset();
    test_addi();
    test_lw();
    test_sw();
    test_back_to_back_beq();
    test_jal();
    test_illegal();
    test_reset_mid_mem();
    test_instret_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
